// File: rtl/one_port_mem_pkg.sv
// Shared defaults and channel-select type for the single-port memory controller.
package one_port_mem_pkg;
  localparam int AW_DEFAULT        = 11;
  localparam int DW_DEFAULT        = 8;
  localparam int RSP_DEPTH_DEFAULT = 2;

  typedef enum logic {
    SEL_WR = 1'b0,
    SEL_RD = 1'b1
  } sel_e;

  function automatic sel_e other_sel(input sel_e s);
    return (s == SEL_WR) ? SEL_RD : SEL_WR;
  endfunction
endpackage

// File: rtl/one_port_mem_rsp_fifo.sv
// In-order read-response buffer; head is read from registered storage, never straight from Q.
module one_port_mem_rsp_fifo
  import one_port_mem_pkg::*;
#(
  parameter int DW    = DW_DEFAULT,
  parameter int DEPTH = RSP_DEPTH_DEFAULT,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [CW-1:0] count,
  output logic [DW-1:0] head
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] store [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= ptr_inc(wptr);
      if (pop)  rptr <= ptr_inc(rptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // No reset on storage: entries become unreachable once the pointers clear.
  always_ff @(posedge CLK) begin
    if (push) store[wptr] <= push_data;
  end

  assign head = store[rptr];
endmodule

// File: rtl/one_port_mem_ctrl.sv
// Sole master of a single-port synchronous memory: round-robin write/read arbitration
// with credit-limited reads feeding an in-order response buffer.
module one_port_mem_ctrl
  import one_port_mem_pkg::*;
#(
  parameter int AW        = AW_DEFAULT,
  parameter int DW        = DW_DEFAULT,
  parameter int RSP_DEPTH = RSP_DEPTH_DEFAULT
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_valid,
  output logic          rd_ready,
  input  logic [AW-1:0] rd_addr,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic [AW-1:0] A,
  output logic          CEN,
  output logic          WEN,
  output logic [DW-1:0] D,
  output logic          OEN,
  input  logic [DW-1:0] Q
);
  localparam int CW  = $clog2(RSP_DEPTH + 1);
  localparam int CRW = CW + 1;

  logic [CW-1:0]  fifo_count;
  logic [CRW-1:0] credits;
  logic           inflight;
  sel_e           rr;
  logic [AW-1:0]  a_q;
  logic [DW-1:0]  d_q;
  logic           wr_elig;
  logic           rd_elig;
  logic           both_elig;
  logic           grant_wr;
  logic           grant_rd;

  // Reset gates eligibility so the pins go idle the moment RST rises.
  assign credits   = CRW'(RSP_DEPTH) - CRW'(fifo_count) - CRW'(inflight);
  assign wr_elig   = !RST && wr_valid;
  assign rd_elig   = !RST && rd_valid && (credits != '0);
  assign both_elig = wr_elig && rd_elig;
  assign grant_wr  = wr_elig && (!rd_elig || rr == SEL_WR);
  assign grant_rd  = rd_elig && (!wr_elig || rr == SEL_RD);

  assign wr_ready = grant_wr;
  assign rd_ready = grant_rd;

  assign CEN = !(grant_wr || grant_rd);
  assign WEN = !grant_wr;
  assign A   = grant_wr ? wr_addr : (grant_rd ? rd_addr : a_q);
  assign D   = grant_wr ? wr_data : d_q;
  assign OEN = 1'b0;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      inflight <= 1'b0;
      rr       <= SEL_WR;
      a_q      <= '0;
      d_q      <= '0;
    end else begin
      inflight <= grant_rd;
      a_q      <= A;
      d_q      <= D;
      if (both_elig) rr <= other_sel(rr);
    end
  end

  // Q is valid the cycle after a read issue, which is exactly when inflight is set.
  one_port_mem_rsp_fifo #(
    .DW    (DW),
    .DEPTH (RSP_DEPTH),
    .CW    (CW)
  ) u_rsp_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (inflight),
    .push_data (Q),
    .pop       (rsp_valid && rsp_ready),
    .count     (fifo_count),
    .head      (rsp_data)
  );

  assign rsp_valid = (fifo_count != '0);
endmodule

// File: tb/tb_one_port_mem_ctrl.sv
// Self-checking bench: behavioural memory, transaction-level reference model, scenario tasks.
module tb_one_port_mem_ctrl;
  localparam int AW    = 11;
  localparam int DW    = 8;
  localparam int DEPTH = 2;

  logic          CLK = 1'b0;
  logic          RST;
  logic          wr_valid, wr_ready, rd_valid, rd_ready, rsp_valid, rsp_ready;
  logic [AW-1:0] wr_addr, rd_addr, A;
  logic [DW-1:0] wr_data, rsp_data, D, Q;
  logic          CEN, WEN, OEN;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 CLK = ~CLK;

  one_port_mem_ctrl #(.AW(AW), .DW(DW), .RSP_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .A(A), .CEN(CEN), .WEN(WEN), .D(D), .OEN(OEN), .Q(Q)
  );

  function automatic logic [DW-1:0] seed_val(input int i);
    return DW'(i * 29 + (i >> 4) + 7);
  endfunction

  // Single-port synchronous memory: Q updates one edge after a read and holds otherwise.
  logic [DW-1:0] mem [2**AW];
  initial begin
    Q = '0;
    for (int i = 0; i < 2**AW; i++) mem[i] = seed_val(i);
    forever begin
      @(posedge CLK);
      if (!CEN) begin
        if (!WEN) mem[A] <= D;
        else      Q      <= mem[A];
      end
    end
  end

  // Reference model: outstanding reads as a queue of (data, cycle it becomes visible).
  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } rsp_t;
  rsp_t          pend[$];
  logic [DW-1:0] ref_mem [2**AW];
  bit            rr_rd;
  logic [AW-1:0] last_a;
  logic [DW-1:0] last_d;
  bit            e_wr, e_rd, e_both, e_cen, e_wen, e_rsp_valid;
  logic [AW-1:0] e_a;
  logic [DW-1:0] e_d, e_rsp_data;

  function automatic void model_expect();
    bit rd_ok;
    rd_ok  = rd_valid && (pend.size() < DEPTH);
    e_both = wr_valid && rd_ok;
    e_wr   = e_both ? !rr_rd : wr_valid;
    e_rd   = e_both ? rr_rd  : rd_ok;
    e_cen  = !(e_wr || e_rd);
    e_wen  = !e_wr;
    e_a    = e_wr ? wr_addr : (e_rd ? rd_addr : last_a);
    e_d    = e_wr ? wr_data : last_d;
    e_rsp_valid = 1'b0;
    e_rsp_data  = '0;
    if (pend.size() > 0) begin
      e_rsp_valid = (pend[0].due <= cyc);
      e_rsp_data  = pend[0].data;
    end
  endfunction

  function automatic void model_commit();
    rsp_t r;
    if (e_rsp_valid && rsp_ready) void'(pend.pop_front());
    if (e_wr) ref_mem[wr_addr] = wr_data;
    if (e_rd) begin
      r.data = ref_mem[rd_addr];
      r.due  = cyc + 2;
      pend.push_back(r);
    end
    if (e_both) rr_rd = !rr_rd;
    last_a = e_a;
    last_d = e_d;
  endfunction

  task automatic drive(input bit wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input bit rv, input logic [AW-1:0] ra, input bit rrdy);
    wr_valid = wv; wr_addr = wa; wr_data = wd;
    rd_valid = rv; rd_addr = ra; rsp_ready = rrdy;
    model_expect();
  endtask

  task automatic tick();
    model_commit();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    wr_valid = 1'b0; rd_valid = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(posedge CLK);
    pend.delete();
    rr_rd = 1'b0; last_a = '0; last_d = '0; cyc = 0;
    #1 RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    wr_valid = 1'b0; rd_valid = 1'b0; rsp_ready = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    #1 RST = 1'b1;
    #11;
    n_checks++;
    if (CEN !== 1'b1 || WEN !== 1'b1 || OEN !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_ctrl_pins: CEN=%b WEN=%b OEN=%b, required 1 1 0", CEN, WEN, OEN);
    end
    n_checks++;
    if (A !== '0 || D !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_addr_data: A=%h D=%h, required 0 0", A, D);
    end
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_rsp_valid: got %b, required 0", rsp_valid);
    end
    do_reset();
    drive(1'b1, 11'h055, 8'h66, 1'b0, '0, 1'b1);
    @(negedge CLK);
    n_checks++;
    if (wr_ready !== 1'b1 || CEN !== 1'b0 || WEN !== 1'b0 || A !== 11'h055 || D !== 8'h66) begin
      n_fail++;
      $display("[TB] FAIL first_edge_write: wr_ready=%b CEN=%b WEN=%b A=%h D=%h, required 1 0 0 055 66",
               wr_ready, CEN, WEN, A, D);
    end
    tick();
  endtask

  task automatic test_wr_rd_basic();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      case (i)
        0:       drive(1'b1, 11'h000, 8'hA5, 1'b0, '0, 1'b1);
        1:       drive(1'b1, 11'h7FF, 8'h3C, 1'b0, '0, 1'b1);
        2:       drive(1'b0, '0, '0, 1'b1, 11'h000, 1'b1);
        3:       drive(1'b0, '0, '0, 1'b1, 11'h7FF, 1'b1);
        default: drive(1'b0, '0, '0, 1'b0, '0, 1'b1);
      endcase
      @(negedge CLK);
      n_checks++;
      if (wr_ready !== e_wr || rd_ready !== e_rd) begin
        n_fail++;
        $display("[TB] FAIL basic_ready c%0d: wr=%b rd=%b, required %b %b", i, wr_ready, rd_ready, e_wr, e_rd);
      end
      n_checks++;
      if (CEN !== e_cen || WEN !== e_wen || A !== e_a || D !== e_d) begin
        n_fail++;
        $display("[TB] FAIL basic_pins c%0d: CEN=%b WEN=%b A=%h D=%h, required %b %b %h %h",
                 i, CEN, WEN, A, D, e_cen, e_wen, e_a, e_d);
      end
      n_checks++;
      if (rsp_valid !== ((i == 4) || (i == 5))) begin
        n_fail++;
        $display("[TB] FAIL basic_rsp_valid c%0d: got %b, required %b", i, rsp_valid, (i == 4) || (i == 5));
      end
      if (i == 4) begin
        n_checks++;
        if (rsp_data !== 8'hA5) begin
          n_fail++;
          $display("[TB] FAIL basic_rsp0: got %h, required a5", rsp_data);
        end
      end
      if (i == 5) begin
        n_checks++;
        if (rsp_data !== 8'h3C) begin
          n_fail++;
          $display("[TB] FAIL basic_rsp1: got %h, required 3c", rsp_data);
        end
      end
      tick();
    end
  endtask

  task automatic test_arbitration();
    bit want_w;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, AW'($urandom_range(256, 511)), DW'($urandom), 1'b1, AW'($urandom_range(256, 511)), 1'b1);
      want_w = (i % 2 == 0);
      @(negedge CLK);
      n_checks++;
      if (wr_ready !== want_w || rd_ready !== !want_w) begin
        n_fail++;
        $display("[TB] FAIL arb_grant c%0d: wr=%b rd=%b, required %b %b", i, wr_ready, rd_ready, want_w, !want_w);
      end
      n_checks++;
      if (rsp_valid !== e_rsp_valid || (e_rsp_valid && rsp_data !== e_rsp_data)) begin
        n_fail++;
        $display("[TB] FAIL arb_rsp c%0d: valid=%b data=%h, required %b %h", i, rsp_valid, rsp_data, e_rsp_valid, e_rsp_data);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int accepted = 0;
    int got = 0;
    logic [DW-1:0] exp0, exp1, want;
    do_reset();
    exp0 = ref_mem[11'h010];
    exp1 = ref_mem[11'h011];
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, '0, 1'b1, AW'(16 + i), 1'b0);
      @(negedge CLK);
      if (rd_ready === 1'b1) accepted++;
      n_checks++;
      if (rd_ready !== (i < 2)) begin
        n_fail++;
        $display("[TB] FAIL bp_rd_ready c%0d: got %b, required %b", i, rd_ready, i < 2);
      end
      tick();
    end
    n_checks++;
    if (accepted != 2) begin
      n_fail++;
      $display("[TB] FAIL bp_accept_count: got %0d, required 2", accepted);
    end
    drive(1'b1, 11'h200, 8'h5A, 1'b1, 11'h012, 1'b0);
    @(negedge CLK);
    n_checks++;
    if (wr_ready !== 1'b1 || rd_ready !== 1'b0 || rsp_valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL bp_full_write: wr=%b rd=%b rsp_valid=%b, required 1 0 1", wr_ready, rd_ready, rsp_valid);
    end
    tick();
    for (int i = 0; i < 8 && got < 2; i++) begin
      drive(1'b0, '0, '0, 1'b0, '0, 1'b1);
      @(negedge CLK);
      if (rsp_valid === 1'b1) begin
        want = (got == 0) ? exp0 : exp1;
        n_checks++;
        if (rsp_data !== want) begin
          n_fail++;
          $display("[TB] FAIL bp_drain_data #%0d: got %h, required %h", got, rsp_data, want);
        end
        got++;
      end
      tick();
    end
    n_checks++;
    if (got != 2) begin
      n_fail++;
      $display("[TB] FAIL bp_drain_timeout: got %0d responses, required 2", got);
    end
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1);
    @(negedge CLK);
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL bp_extra_rsp: rsp_valid=%b, required 0", rsp_valid);
    end
    tick();
  endtask

  task automatic test_wr_then_rd();
    do_reset();
    drive(1'b1, 11'h123, 8'h11, 1'b0, '0, 1'b1);
    @(negedge CLK);
    n_checks++;
    if (wr_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL raw_write_accept: got %b, required 1", wr_ready);
    end
    tick();
    drive(1'b0, '0, '0, 1'b1, 11'h123, 1'b1);
    @(negedge CLK);
    n_checks++;
    if (rd_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL raw_read_accept: got %b, required 1", rd_ready);
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, '0, '0, 1'b0, '0, 1'b1);
      @(negedge CLK);
      n_checks++;
      if (rsp_valid !== (k == 1) || (k == 1 && rsp_data !== 8'h11)) begin
        n_fail++;
        $display("[TB] FAIL raw_rsp k%0d: valid=%b data=%h, required %b 11", k, rsp_valid, rsp_data, k == 1);
      end
      tick();
    end
  endtask

  task automatic test_reset_inflight();
    logic [DW-1:0] want;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, '0, '0, 1'b1, AW'(32 + i), 1'b0);
      @(negedge CLK);
      n_checks++;
      if (rd_ready !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL rst_pre_read c%0d: got %b, required 1", i, rd_ready);
      end
      tick();
    end
    drive(1'b0, '0, '0, 1'b1, 11'h022, 1'b0);
    @(negedge CLK);
    n_checks++;
    if (rsp_valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL rst_buffered: rsp_valid=%b, required 1", rsp_valid);
    end
    RST = 1'b1;
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0 || CEN !== 1'b1 || rd_ready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL rst_async: rsp_valid=%b CEN=%b rd_ready=%b, required 0 1 0", rsp_valid, CEN, rd_ready);
    end
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, '0, '0, 1'b0, '0, 1'b1);
      @(negedge CLK);
      n_checks++;
      if (rsp_valid !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL rst_stale_rsp c%0d: rsp_valid=%b data=%h, required 0", i, rsp_valid, rsp_data);
      end
      tick();
    end
    want = ref_mem[11'h021];
    drive(1'b0, '0, '0, 1'b1, 11'h021, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1);
    @(negedge CLK);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== want) begin
      n_fail++;
      $display("[TB] FAIL rst_fresh_read: valid=%b data=%h, required 1 %h", rsp_valid, rsp_data, want);
    end
    tick();
  endtask

  function automatic logic [AW-1:0] pick_addr();
    if ($urandom_range(0, 1) == 0) return AW'(32'h40 + $urandom_range(0, 7));
    return AW'((2**AW - 1) - int'($urandom_range(0, 3)));
  endfunction

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, pick_addr(), DW'($urandom),
            $urandom_range(0, 2) != 0, pick_addr(), $urandom_range(0, 3) != 0);
      @(negedge CLK);
      n_checks++;
      if (wr_ready !== e_wr || rd_ready !== e_rd) begin
        n_fail++;
        $display("[TB] FAIL rnd_ready c%0d: wr=%b rd=%b, required %b %b", i, wr_ready, rd_ready, e_wr, e_rd);
      end
      n_checks++;
      if (wr_ready === 1'b1 && rd_ready === 1'b1) begin
        n_fail++;
        $display("[TB] FAIL rnd_exclusive c%0d: both readies high, required at most one", i);
      end
      n_checks++;
      if (CEN !== e_cen || WEN !== e_wen || A !== e_a || D !== e_d) begin
        n_fail++;
        $display("[TB] FAIL rnd_pins c%0d: CEN=%b WEN=%b A=%h D=%h, required %b %b %h %h",
                 i, CEN, WEN, A, D, e_cen, e_wen, e_a, e_d);
      end
      n_checks++;
      if (rsp_valid !== e_rsp_valid || (e_rsp_valid && rsp_data !== e_rsp_data)) begin
        n_fail++;
        $display("[TB] FAIL rnd_rsp c%0d: valid=%b data=%h, required %b %h", i, rsp_valid, rsp_data, e_rsp_valid, e_rsp_data);
      end
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) ref_mem[i] = seed_val(i);
    test_reset();
    test_wr_rd_basic();
    test_arbitration();
    test_backpressure();
    test_wr_then_rd();
    test_reset_inflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion before 1 ms");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule

// File: doc/one_port_mem_ctrl.md
ONE_PORT_MEM_CTRL -- requirements
Module: one_port_mem_ctrl

Interface
REQ-001 Parameters SHALL be as follows; each line gives name, default and meaning.
- AW, 11, address width.
- DW, 8, data width.
- RSP_DEPTH, 2, response buffer entries (minimum 2).
REQ-002 Ports SHALL be as follows; each line gives name, direction, width and meaning.
- CLK, in, 1, sole clock; all state updates on the rising edge.
- RST, in, 1, asynchronous active-high reset.
- wr_valid, in, 1, write request present.
- wr_ready, out, 1, write accepted this cycle.
- wr_addr, in, AW, write address.
- wr_data, in, DW, write data.
- rd_valid, in, 1, read request present.
- rd_ready, out, 1, read accepted this cycle.
- rd_addr, in, AW, read address.
- rsp_valid, out, 1, read data available.
- rsp_ready, in, 1, consumer takes read data.
- rsp_data, out, DW, read data, in request order.
- A, out, AW, memory address.
- CEN, out, 1, memory chip enable, active-low.
- WEN, out, 1, memory write enable, active-low (1 = read).
- D, out, DW, memory write data.
- OEN, out, 1, memory output enable; constant 0.
- Q, in, DW, memory read data.

Function
REQ-003 The block SHALL be the sole master of one single-port synchronous memory (write or read per CLK edge, read data on Q one edge after issue, Q held until the next read).
REQ-004 A transfer SHALL occur on a channel when valid && ready in the same cycle; the ready signals SHALL be combinational from valids, rr pointer and credits, and at most one of wr_ready/rd_ready SHALL be 1 per cycle.
REQ-005 Eligibility: a write SHALL be eligible whenever wr_valid=1; a read SHALL be eligible when rd_valid=1 && credits>0, where credits = RSP_DEPTH - fifo_count - inflight.
REQ-006 Arbitration: with one eligible channel, that channel SHALL be granted; with both eligible, the channel named by the 1-bit rr pointer SHALL be granted; rr SHALL flip to the other channel after every grant made while both were eligible.
REQ-007 Memory pins in a granted-write cycle SHALL be CEN=0, WEN=0, A=wr_addr, D=wr_data.
REQ-008 Memory pins in a granted-read cycle SHALL be CEN=0, WEN=1, A=rd_addr.
REQ-009 Memory pins in a cycle with no grant SHALL be CEN=1, WEN=1, with A and D held at their last value.
REQ-010 A read granted in cycle N SHALL set inflight for cycle N+1; in N+1, Q SHALL be pushed into the response FIFO; minimum read latency (rd accept to rsp_valid) SHALL be 2 cycles.
REQ-011 Response FIFO: RSP_DEPTH entries, in order, with rsp_valid = (count>0) and rsp_data = head entry (registered output, no combinational Q-to-rsp_data path).
REQ-012 Simultaneous push and pop SHALL leave count unchanged; the credit rule SHALL make overflow impossible, and pop on empty cannot occur.
REQ-013 With the FIFO full and rsp_ready=0, rd_ready SHALL be 0 while write traffic continues unaffected.
REQ-014 A write to X in cycle N followed by a read of X in any later cycle SHALL return the new data.
REQ-015 Address wrap SHALL be none; A is passed through unmodified across the full 0..2^AW-1 range.

Reset
REQ-016 RST=1 SHALL asynchronously force CEN=1, WEN=1, A=0, D=0, rsp_valid=0, inflight=0, fifo_count=0, and rr=write.
REQ-017 A read in flight or buffered when RST asserts SHALL be discarded with no response produced; memory contents are unaffected by reset.
REQ-018 The first edge after RST deasserts SHALL accept requests normally.

Structure
REQ-019 Package one_port_mem_pkg SHALL hold the AW/DW/RSP_DEPTH defaults and the channel-select enum (SEL_WR, SEL_RD).
REQ-020 The response FIFO SHALL be the sub-module one_port_mem_rsp_fifo (push, pop, count, head data).
REQ-021 The memory model SHALL be instantiated only in the testbench.

Verification
REQ-022 The bench SHALL cover these five scenarios.
- Write 0xA5 to 0x000 and 0x3C to 0x7FF, then read both with rsp_ready=1: rsp_data is 0xA5 then 0x3C, each arriving 2 cycles after its read accept.
- wr_valid=rd_valid=1 held for 6 cycles after reset: grants go W,R,W,R,W,R.
- rsp_ready=0 with 4 back-to-back reads: exactly 2 are accepted, then rd_ready=0; after rsp_ready=1, data arrives in order with no loss.
- Write 0x11 to 0x123 in cycle N and read 0x123 in cycle N+1: returns 0x11.
- RST pulsed while one read is in flight and one is buffered: rsp_valid=0 and CEN=1 immediately, and no stale response appears afterward.
